// File: rtl/vend_pkg.sv
// Shared types and coin values for the credit-based vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } vend_state_t;

  localparam int QUARTER_VAL = 25;
  localparam int DOLLAR_VAL  = 100;

endpackage

// File: rtl/vend_credit_machine_if.sv
// Coin/cancel inputs and dispense/change outputs of the vending controller.
// The restock line exists only when VEND_STOCK_EN is defined.
interface vend_credit_machine_if #(parameter int CREDIT_W = 8);
  import vend_pkg::*;

  logic                Q_in;
  logic                D_in;
  logic                cancel;
`ifdef VEND_STOCK_EN
  logic                restock;
`endif
  logic                Dispense;
  logic                Change;
  logic [CREDIT_W-1:0] change_amt;
  logic [CREDIT_W-1:0] credit;
  logic                Empty;
  vend_state_t         state;

  modport master (
`ifdef VEND_STOCK_EN
    output restock,
`endif
    output Q_in, D_in, cancel,
    input  Dispense, Change, change_amt, credit, Empty, state
  );

  modport slave (
`ifdef VEND_STOCK_EN
    input  restock,
`endif
    input  Q_in, D_in, cancel,
    output Dispense, Change, change_amt, credit, Empty, state
  );

endinterface

// File: rtl/vend_stock_ctr.sv
// Item stock counter: reloads on restock, decrements on dispense, never wraps.
module vend_stock_ctr #(
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 15
) (
  input  logic clock,
  input  logic rst,
  input  logic restock,
  input  logic dec,
  output logic empty
);

  logic [STOCK_W-1:0] stock;

  // Restock wins over a same-edge decrement; empty tracks the next stock value.
  always_ff @(posedge clock) begin
    if (rst) begin
      stock <= STOCK_W'(INIT_STOCK);
      empty <= (INIT_STOCK == 0);
    end else if (restock) begin
      stock <= STOCK_W'(INIT_STOCK);
      empty <= (INIT_STOCK == 0);
    end else if (dec && (stock != '0)) begin
      stock <= stock - 1'b1;
      empty <= (stock == STOCK_W'(1));
    end
  end

endmodule

// File: rtl/vend_credit_machine.sv
// Credit-accumulating vending controller with registered dispense/change pulses.
// Optional stock tracking and restock are compiled in with VEND_STOCK_EN.
module vend_credit_machine
  import vend_pkg::*;
#(
  parameter int PRICE      = 75,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 15
) (
  input logic                  clock,
  input logic                  rst,
  vend_credit_machine_if.slave bus
);

  if (2**CREDIT_W <= PRICE + 124) begin : g_bad_credit_w
    $error("CREDIT_W too narrow for PRICE plus a dollar and a quarter");
  end
  if (INIT_STOCK > 2**STOCK_W - 1) begin : g_bad_init_stock
    $error("INIT_STOCK does not fit in STOCK_W bits");
  end

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] credit_q;
  logic                stock_ok;
  logic                vend_go;
  vend_state_t         state_q;

  always_comb begin
    coin_val = '0;
    if (bus.Q_in) coin_val = coin_val + CREDIT_W'(QUARTER_VAL);
    if (bus.D_in) coin_val = coin_val + CREDIT_W'(DOLLAR_VAL);
    sum = credit_q + coin_val;
  end

  assign vend_go = !bus.cancel && stock_ok && (sum >= CREDIT_W'(PRICE));

`ifdef VEND_STOCK_EN
  logic stock_empty;

  vend_stock_ctr #(
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clock   (clock),
    .rst     (rst),
    .restock (bus.restock),
    .dec     (vend_go),
    .empty   (stock_empty)
  );

  assign stock_ok  = !stock_empty;
  assign bus.Empty = stock_empty;
`else
  assign stock_ok  = 1'b1;
  assign bus.Empty = 1'b0;
`endif

  // Priority: cancel, then sold-out refund of new coins, then vend, then collect.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      bus.Dispense   <= 1'b0;
      bus.Change     <= 1'b0;
      bus.change_amt <= '0;
    end else begin
      bus.Dispense   <= 1'b0;
      bus.Change     <= 1'b0;
      bus.change_amt <= '0;
      if (bus.cancel) begin
        credit_q       <= '0;
        bus.change_amt <= sum;
        bus.Change     <= (sum != '0);
        state_q        <= (sum != '0) ? REFUND : IDLE;
      end else if ((coin_val != '0) && !stock_ok) begin
        bus.change_amt <= coin_val;
        bus.Change     <= 1'b1;
        state_q        <= REFUND;
      end else if (vend_go) begin
        credit_q       <= '0;
        bus.Dispense   <= 1'b1;
        bus.change_amt <= sum - CREDIT_W'(PRICE);
        bus.Change     <= (sum != CREDIT_W'(PRICE));
        state_q        <= VEND;
      end else begin
        credit_q <= sum;
        state_q  <= (sum != '0) ? COLLECT : IDLE;
      end
    end
  end

  assign bus.credit = credit_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_vend_credit_machine.sv
// Self-checking bench for vend_credit_machine: directed scenarios plus random
// coin/cancel/restock/reset traffic against a cents-level reference model.
module tb_vend_credit_machine;
  import vend_pkg::*;

  localparam int PRICE    = 75;
  localparam int CREDIT_W = 8;
  localparam int STOCK_W  = 4;
`ifdef VEND_STOCK_EN
  localparam int INIT_STOCK = 1;
  localparam bit STOCK_EN   = 1'b1;
`else
  localparam int INIT_STOCK = 15;
  localparam bit STOCK_EN   = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vend_credit_machine_if #(.CREDIT_W(CREDIT_W)) bus ();

  vend_credit_machine #(
    .PRICE      (PRICE),
    .CREDIT_W   (CREDIT_W),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state in plain cents / item counts.
  int                  m_credit;
  int                  m_stock;
  logic                exp_disp;
  logic                exp_chg;
  logic [CREDIT_W-1:0] exp_amt;
  logic [CREDIT_W-1:0] exp_credit;
  logic                exp_empty;
  vend_state_t         exp_state;

  function automatic void model_edge(input logic q, input logic d, input logic c,
                                     input logic rs, input logic r);
    int v, total, amt;
    bit have_stock;
    bit sold;
    exp_disp = 1'b0;
    exp_chg  = 1'b0;
    amt      = 0;
    sold     = 1'b0;
    if (r) begin
      m_credit  = 0;
      m_stock   = INIT_STOCK;
      exp_state = IDLE;
    end else begin
      v          = (q ? 25 : 0) + (d ? 100 : 0);
      total      = m_credit + v;
      have_stock = !STOCK_EN || (m_stock > 0);
      if (c) begin
        amt       = total;
        exp_chg   = (total > 0);
        m_credit  = 0;
        exp_state = (total > 0) ? REFUND : IDLE;
      end else if (v > 0 && !have_stock) begin
        amt       = v;
        exp_chg   = 1'b1;
        exp_state = REFUND;
      end else if (total >= PRICE) begin
        amt       = total - PRICE;
        exp_disp  = 1'b1;
        exp_chg   = (amt != 0);
        m_credit  = 0;
        sold      = 1'b1;
        exp_state = VEND;
      end else begin
        m_credit  = total;
        exp_state = (total > 0) ? COLLECT : IDLE;
      end
      if (STOCK_EN && rs) m_stock = INIT_STOCK;
      else if (STOCK_EN && sold && m_stock > 0) m_stock = m_stock - 1;
    end
    exp_amt    = CREDIT_W'(amt);
    exp_credit = CREDIT_W'(m_credit);
    exp_empty  = STOCK_EN && (m_stock == 0);
  endfunction

  task automatic drive(input logic q, input logic d, input logic c,
                       input logic rs, input logic r);
    bus.Q_in   = q;
    bus.D_in   = d;
    bus.cancel = c;
`ifdef VEND_STOCK_EN
    bus.restock = rs;
`endif
    rst = r;
    @(posedge clock);
    model_edge(q, d, c, rs, r);
    #1;
    bus.Q_in   = 1'b0;
    bus.D_in   = 1'b0;
    bus.cancel = 1'b0;
`ifdef VEND_STOCK_EN
    bus.restock = 1'b0;
`endif
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 1, 1);
    checks++; if (bus.Dispense !== 1'b0) begin errors++; $display("FAIL reset_dispense got=%b want=0", bus.Dispense); end
    checks++; if (bus.Change !== 1'b0) begin errors++; $display("FAIL reset_change got=%b want=0", bus.Change); end
    checks++; if (bus.change_amt !== 8'd0) begin errors++; $display("FAIL reset_amt got=%0d want=0", bus.change_amt); end
    checks++; if (bus.credit !== 8'd0) begin errors++; $display("FAIL reset_credit got=%0d want=0", bus.credit); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", bus.state, IDLE); end
    checks++; if (bus.Empty !== 1'b0) begin errors++; $display("FAIL reset_empty got=%b want=0", bus.Empty); end
  endtask

  task automatic test_quarters();
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    checks++; if (bus.credit !== 8'd25) begin errors++; $display("FAIL q1_credit got=%0d want=25", bus.credit); end
    checks++; if (bus.state !== COLLECT) begin errors++; $display("FAIL q1_state got=%0d want=%0d", bus.state, COLLECT); end
    drive(1, 0, 0, 0, 0);
    checks++; if (bus.credit !== 8'd50) begin errors++; $display("FAIL q2_credit got=%0d want=50", bus.credit); end
    drive(1, 0, 0, 0, 0);
    checks++; if (bus.Dispense !== 1'b1) begin errors++; $display("FAIL q3_dispense got=%b want=1", bus.Dispense); end
    checks++; if (bus.Change !== 1'b0) begin errors++; $display("FAIL q3_change got=%b want=0", bus.Change); end
    checks++; if (bus.credit !== 8'd0) begin errors++; $display("FAIL q3_credit got=%0d want=0", bus.credit); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.Dispense !== 1'b0) begin errors++; $display("FAIL pulse_width got=%b want=0", bus.Dispense); end
  endtask

  task automatic test_dollar();
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0);
    checks++; if (bus.Dispense !== 1'b1) begin errors++; $display("FAIL dollar_dispense got=%b want=1", bus.Dispense); end
    checks++; if (bus.Change !== 1'b1) begin errors++; $display("FAIL dollar_change got=%b want=1", bus.Change); end
    checks++; if (bus.change_amt !== 8'd25) begin errors++; $display("FAIL dollar_amt got=%0d want=25", bus.change_amt); end
  endtask

  task automatic test_cancel();
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    checks++; if (bus.Change !== 1'b1) begin errors++; $display("FAIL cancel_change got=%b want=1", bus.Change); end
    checks++; if (bus.change_amt !== 8'd50) begin errors++; $display("FAIL cancel_amt got=%0d want=50", bus.change_amt); end
    checks++; if (bus.Dispense !== 1'b0) begin errors++; $display("FAIL cancel_dispense got=%b want=0", bus.Dispense); end
    checks++; if (bus.credit !== 8'd0) begin errors++; $display("FAIL cancel_credit got=%0d want=0", bus.credit); end
    checks++; if (bus.state !== REFUND) begin errors++; $display("FAIL cancel_state got=%0d want=%0d", bus.state, REFUND); end
    drive(0, 0, 1, 0, 0);
    checks++; if (bus.Change !== 1'b0) begin errors++; $display("FAIL cancel_empty_change got=%b want=0", bus.Change); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL cancel_empty_state got=%0d want=%0d", bus.state, IDLE); end
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    checks++; if (bus.change_amt !== 8'd125) begin errors++; $display("FAIL cancel_coin_amt got=%0d want=125", bus.change_amt); end
  endtask

  task automatic test_both_coins();
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    checks++; if (bus.Dispense !== 1'b1) begin errors++; $display("FAIL both_dispense got=%b want=1", bus.Dispense); end
    checks++; if (bus.change_amt !== 8'd50) begin errors++; $display("FAIL both_amt got=%0d want=50", bus.change_amt); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    checks++; if (bus.Dispense !== exp_disp) begin errors++; $display("FAIL b2b_dispense got=%b want=%b", bus.Dispense, exp_disp); end
    checks++; if (bus.state !== exp_state) begin errors++; $display("FAIL b2b_state got=%0d want=%0d", bus.state, exp_state); end
  endtask

  task automatic test_reset_override();
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    checks++; if (bus.Dispense !== 1'b0) begin errors++; $display("FAIL rstov_dispense got=%b want=0", bus.Dispense); end
    checks++; if (bus.Change !== 1'b0) begin errors++; $display("FAIL rstov_change got=%b want=0", bus.Change); end
    checks++; if (bus.change_amt !== 8'd0) begin errors++; $display("FAIL rstov_amt got=%0d want=0", bus.change_amt); end
    checks++; if (bus.credit !== 8'd0) begin errors++; $display("FAIL rstov_credit got=%0d want=0", bus.credit); end
  endtask

`ifdef VEND_STOCK_EN
  task automatic test_stock();
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0);
    checks++; if (bus.Dispense !== 1'b1) begin errors++; $display("FAIL stock_first_dispense got=%b want=1", bus.Dispense); end
    checks++; if (bus.Empty !== 1'b1) begin errors++; $display("FAIL stock_first_empty got=%b want=1", bus.Empty); end
    drive(0, 1, 0, 0, 0);
    checks++; if (bus.Change !== 1'b1) begin errors++; $display("FAIL sold_out_change got=%b want=1", bus.Change); end
    checks++; if (bus.change_amt !== 8'd100) begin errors++; $display("FAIL sold_out_amt got=%0d want=100", bus.change_amt); end
    checks++; if (bus.Dispense !== 1'b0) begin errors++; $display("FAIL sold_out_dispense got=%b want=0", bus.Dispense); end
    drive(0, 0, 0, 1, 0);
    checks++; if (bus.Empty !== 1'b0) begin errors++; $display("FAIL restock_empty got=%b want=0", bus.Empty); end
  endtask
`endif

  task automatic test_random();
    logic q, d, c, rs, r;
    for (int i = 0; i < 600; i++) begin
      q  = ($urandom_range(0, 9) < 4);
      d  = ($urandom_range(0, 9) < 2);
      c  = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 59) == 0);
      drive(q, d, c, rs, r);
      checks++;
      if (bus.Dispense !== exp_disp || bus.Change !== exp_chg || bus.change_amt !== exp_amt ||
          bus.credit !== exp_credit || bus.Empty !== exp_empty || bus.state !== exp_state) begin
        errors++;
        $display("FAIL random[%0d] got disp=%b chg=%b amt=%0d cred=%0d empty=%b st=%0d want disp=%b chg=%b amt=%0d cred=%0d empty=%b st=%0d",
                 i, bus.Dispense, bus.Change, bus.change_amt, bus.credit, bus.Empty, bus.state,
                 exp_disp, exp_chg, exp_amt, exp_credit, exp_empty, exp_state);
      end
      checks++;
      if (!(bus.credit < 8'(PRICE))) begin
        errors++;
        $display("FAIL credit_bound[%0d] got=%0d want<%0d", i, bus.credit, PRICE);
      end
    end
  endtask

  initial begin
    bus.Q_in   = 1'b0;
    bus.D_in   = 1'b0;
    bus.cancel = 1'b0;
`ifdef VEND_STOCK_EN
    bus.restock = 1'b0;
`endif
    m_credit = 0;
    m_stock  = INIT_STOCK;
    @(negedge clock);
    test_reset();
    test_quarters();
    test_dollar();
    test_cancel();
    test_both_coins();
    test_back_to_back();
    test_reset_override();
`ifdef VEND_STOCK_EN
    test_stock();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_credit_machine.md
VEND_CREDIT_MACHINE -- requirements
Module: vend_credit_machine

Interface
REQ-001 Parameter PRICE, default 75, item price in cents.
REQ-002 Parameter CREDIT_W, default 8, width of credit and change_amt; SHALL satisfy 2**CREDIT_W > PRICE+124.
REQ-003 Parameter STOCK_W, default 4, stock counter width.
REQ-004 Parameter INIT_STOCK, default 15, stock loaded at reset; SHALL be at most 2**STOCK_W-1.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  sole clock; all state updates on its posedge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 Q_in  in  1  quarter inserted, 25 cents, one coin per high cycle.
REQ-009 D_in  in  1  dollar inserted, 100 cents, one coin per high cycle.
REQ-010 cancel  in  1  return all held credit.
REQ-011 restock  in  1  reload stock to INIT_STOCK; present only with VEND_STOCK_EN.
REQ-012 Dispense  out  1  one-cycle item-release pulse.
REQ-013 Change  out  1  one-cycle pulse; change_amt is valid while it is high.
REQ-014 change_amt  out  CREDIT_W  cents returned; 0 when Change is low.
REQ-015 credit  out  CREDIT_W  current held credit.
REQ-016 Empty  out  1  stock is 0; tied 0 without VEND_STOCK_EN.

Function
REQ-017 All outputs SHALL be registered; each response appears exactly 1 cycle after the sampling edge.
REQ-018 Per-edge coin value v SHALL be 25*Q_in + 100*D_in; simultaneous coins add, and sum = credit + v.
REQ-019 FSM states SHALL be IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND and REFUND; VEND and REFUND each last one cycle.
REQ-020 If sum >= PRICE, stock is nonzero and cancel is low: next state VEND; Dispense=1; change_amt=sum-PRICE; Change=(change_amt!=0); credit=0; stock decrements by 1.
REQ-021 If v>0 and stock==0: next state REFUND; Change=1; change_amt=v; credit unchanged.
REQ-022 If cancel=1: change_amt=sum (coins sampled on the same edge are refunded); credit=0.
REQ-023 Cancel outcome: if sum>0, next state REFUND with Change=1; if sum==0, no pulse and next state IDLE.
REQ-024 If 0 < sum < PRICE, cancel is low and stock is nonzero: credit=sum; next state COLLECT.
REQ-025 Coins SHALL also be accepted in VEND and REFUND, with the same rules; VEND->VEND SHALL be legal (back-to-back dollars).
REQ-026 The stock counter SHALL never wrap below 0; Empty SHALL be high exactly when stock==0.
REQ-027 restock SHALL take priority over a decrement on the same edge and SHALL not affect credit.
REQ-028 Credit SHALL never exceed PRICE-1 after any edge.

Reset
REQ-029 When rst is sampled high: state=IDLE; credit=0; Dispense=0; Change=0; change_amt=0; stock=INIT_STOCK; Empty=(INIT_STOCK==0).
REQ-030 rst SHALL override coins, cancel and restock on the same edge; held credit is discarded and not refunded.

Configuration
REQ-031 Macro VEND_STOCK_EN defined: the stock counter, the restock port and a live Empty output are compiled in.
REQ-032 Macro VEND_STOCK_EN undefined: stock is unlimited; REQ-021 never triggers; Empty is tied 0; the restock port is absent.

Structure
REQ-033 Package vend_pkg SHALL hold the state enum vend_state_t and the constants QUARTER_VAL=25 and DOLLAR_VAL=100.
REQ-034 The stock counter SHALL be sub-module vend_stock_ctr, instantiated only under VEND_STOCK_EN.

Verification
REQ-035 Reset, then Q_in high for 3 single-cycle pulses -> credit goes 25, 50; 1 cycle after the third pulse: Dispense=1, Change=0, credit=0.
REQ-036 Reset, then one D_in pulse -> next cycle: Dispense=1, Change=1, change_amt=25.
REQ-037 Q,Q, then cancel -> next cycle: Change=1, change_amt=50, Dispense=0, credit=0.
REQ-038 Q_in and D_in high together -> next cycle: Dispense=1, change_amt=50.
REQ-039 INIT_STOCK=1: dollar then dollar -> first gives Dispense with Empty=1; second gives Change=1, change_amt=100, Dispense=0; then restock -> Empty=0.
REQ-040 Credit 50, then rst asserted together with D_in -> next cycle: all outputs 0 and stock=INIT_STOCK.
